// File: rtl/sanity_ctl.sv
// sanity_ctl: Q-bus sanity timer; on timeout drives a BPOK/BDCOK power-fail sequence.
// Define SANITY_CTL_BPOK_EN to include the BPOK lead (POKF) and lag (DCKR) phases.
module sanity_ctl #(
  parameter int QSEC_DIV  = 625000,
  parameter int BPOK_LEAD = 7500,
  parameter int DCOK_LOW  = 10000,
  parameter int POK_LAG   = 175000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        pwse,
  input  logic [2:0]  sanity,
  input  logic        ena,
  input  logic        kick,
  input  logic        clr_exp,
  output logic        pok_fail,
  output logic        dcok_fail,
  output logic        expired,
  output logic        busy,
  output logic [13:0] remaining
);

  localparam int MAX_AB    = (BPOK_LEAD > DCOK_LOW) ? BPOK_LEAD : DCOK_LOW;
  localparam int MAX_PHASE = (MAX_AB > POK_LAG) ? MAX_AB : POK_LAG;
  localparam int PH_W      = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int PS_W      = (QSEC_DIV > 1) ? $clog2(QSEC_DIV) : 1;

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(QSEC_DIV - 1);
  localparam logic [PH_W-1:0] DCOK_LAST = PH_W'(DCOK_LOW - 1);
`ifdef SANITY_CTL_BPOK_EN
  localparam logic [PH_W-1:0] LEAD_LAST = PH_W'(BPOK_LEAD - 1);
  localparam logic [PH_W-1:0] LAG_LAST  = PH_W'(POK_LAG - 1);
`endif

  typedef enum logic [2:0] {IDLE, RUN, POKF, DCKF, DCKR} state_t;

  state_t          state, state_nxt;
  logic [PS_W-1:0] ps, ps_nxt;
  logic [13:0]     cnt, cnt_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic            arm, arm_nxt;
  logic            exp_set;

  function automatic logic [13:0] load_q(input logic [2:0] code);
    case (code)
      3'd0:    return 14'd1;
      3'd1:    return 14'd4;
      3'd2:    return 14'd16;
      3'd3:    return 14'd64;
      3'd4:    return 14'd240;
      3'd5:    return 14'd960;
      3'd6:    return 14'd3840;
      default: return 14'd15360;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ps_nxt    = '0;
    cnt_nxt   = '0;
    phase_nxt = '0;
    arm_nxt   = arm;
    exp_set   = 1'b0;
    case (state)
      IDLE: begin
        if (ena || arm) begin
          state_nxt = RUN;
          cnt_nxt   = load_q(sanity);
        end
      end
      RUN: begin
        // Priority: leave, then kick (beats an expiring tick), then tick, then count.
        if (!ena && !arm) begin
          state_nxt = IDLE;
        end else if (kick) begin
          cnt_nxt = load_q(sanity);
        end else if (ps == PS_LAST) begin
          if (cnt > 14'd1) begin
            cnt_nxt = cnt - 14'd1;
          end else begin
            exp_set = 1'b1;
`ifdef SANITY_CTL_BPOK_EN
            state_nxt = POKF;
`else
            state_nxt = DCKF;
`endif
          end
        end else begin
          ps_nxt  = ps + PS_W'(1);
          cnt_nxt = cnt;
        end
      end
`ifdef SANITY_CTL_BPOK_EN
      POKF: begin
        if (phase == LEAD_LAST) state_nxt = DCKF;
        else phase_nxt = phase + PH_W'(1);
      end
      DCKF: begin
        if (phase == DCOK_LAST) state_nxt = DCKR;
        else phase_nxt = phase + PH_W'(1);
      end
      DCKR: begin
        if (phase == LAG_LAST) begin
          state_nxt = IDLE;
          arm_nxt   = 1'b0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
`else
      DCKF: begin
        if (phase == DCOK_LAST) begin
          state_nxt = IDLE;
          arm_nxt   = 1'b0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only; outputs are registered from next-state values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ps        <= '0;
      cnt       <= '0;
      phase     <= '0;
      arm       <= pwse;
      pok_fail  <= 1'b0;
      dcok_fail <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      ps        <= ps_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      arm       <= arm_nxt;
`ifdef SANITY_CTL_BPOK_EN
      pok_fail  <= state_nxt inside {POKF, DCKF, DCKR};
`else
      pok_fail  <= 1'b0;
`endif
      dcok_fail <= (state_nxt == DCKF);
      busy      <= state_nxt inside {POKF, DCKF, DCKR};
      expired   <= exp_set | (expired & ~clr_exp);
      remaining <= (state_nxt == RUN) ? cnt_nxt : '0;
    end
  end

endmodule

// File: tb/tb_sanity_ctl.sv
// tb_sanity_ctl: vector tables plus cycle sequences for sanity_ctl with a small-timing build.
// Expectations follow the BPOK phases when SANITY_CTL_BPOK_EN is defined, DCOK-only otherwise.
module tb_sanity_ctl;
  localparam int QD   = 4;
  localparam int LEAD = 3;
  localparam int LOW  = 5;
  localparam int LAG  = 6;
`ifdef SANITY_CTL_BPOK_EN
  localparam bit BPOK = 1'b1;
`else
  localparam bit BPOK = 1'b0;
`endif
  localparam int SEQ_LEN  = BPOK ? (LEAD + LOW + LAG) : LOW;
  localparam int LO_START = BPOK ? LEAD : 0;
  localparam logic [17:0] EXP_BIT = 18'h04000;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        pwse = 1'b0;
  logic [2:0]  sanity = 3'd0;
  logic        ena = 1'b0;
  logic        kick = 1'b0;
  logic        clr_exp = 1'b0;
  logic        pok_fail, dcok_fail, expired, busy;
  logic [13:0] remaining;
  logic [17:0] outs;

  int total = 0;
  int bad = 0;
  logic [17:0] sb_q[$];

  typedef struct { int n; logic [17:0] want; string tag; } seg_t;
  typedef struct { logic [2:0] code; logic [13:0] rem; } ld_t;

  sanity_ctl #(.QSEC_DIV(QD), .BPOK_LEAD(LEAD), .DCOK_LOW(LOW), .POK_LAG(LAG)) dut (
    .clock(clock), .rst(rst), .pwse(pwse), .sanity(sanity), .ena(ena), .kick(kick),
    .clr_exp(clr_exp), .pok_fail(pok_fail), .dcok_fail(dcok_fail), .expired(expired),
    .busy(busy), .remaining(remaining)
  );

  assign outs = {pok_fail, dcok_fail, busy, expired, remaining};

  always #5 clock = ~clock;

  function automatic logic [17:0] ev(input logic p, input logic d, input logic b,
                                     input logic e, input int rem);
    return {p, d, b, e, 14'(rem)};
  endfunction

  // Expected outputs k edges after the expiring tick (k=0 is that edge), expired set.
  function automatic logic [17:0] seq_want(input int k);
    if (k >= SEQ_LEN) return ev(1'b0, 1'b0, 1'b0, 1'b1, 0);
    return ev(BPOK, (k >= LO_START) && (k < LO_START + LOW), 1'b1, 1'b1, 0);
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got pok/dcok/busy/exp/rem=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               name, got[17], got[16], got[15], got[14], got[13:0],
               want[17], want[16], want[15], want[14], want[13:0]);
    end
  endtask

  task automatic cyc(input logic k, input logic c, input logic [17:0] want, input string name);
    kick = k;
    clr_exp = c;
    sb_q.push_back(want);
    @(posedge clock);
    #1;
    kick = 1'b0;
    clr_exp = 1'b0;
    check(name, outs, sb_q.pop_front());
  endtask

  task automatic do_reset(input logic p, input logic e, input logic [2:0] s);
    @(negedge clock);
    rst = 1'b1;
    pwse = p;
    ena = e;
    sanity = s;
    kick = 1'b0;
    clr_exp = 1'b0;
    @(posedge clock);
    #1;
    check("reset_state", outs, 18'h0);
    rst = 1'b0;
    #1;
    check("post_release", outs, 18'h0);
  endtask

  initial begin
    seg_t segs[$];
    ld_t  ld_tab[8];
    int unsigned ld_vals[8] = '{1, 4, 16, 64, 240, 960, 3840, 15360};
    logic [17:0] w;

    for (int i = 0; i < 8; i++) ld_tab[i] = '{3'(i), 14'(ld_vals[i])};

    segs.push_back('{4, ev(1'b0, 1'b0, 1'b0, 1'b0, 1), "arm_run"});
    if (BPOK) begin
      segs.push_back('{LEAD, ev(1'b1, 1'b0, 1'b1, 1'b1, 0), "pokf"});
      segs.push_back('{LOW,  ev(1'b1, 1'b1, 1'b1, 1'b1, 0), "dckf"});
      segs.push_back('{LAG,  ev(1'b1, 1'b0, 1'b1, 1'b1, 0), "dckr"});
    end else begin
      segs.push_back('{LOW,  ev(1'b0, 1'b1, 1'b1, 1'b1, 0), "dckf"});
    end
    segs.push_back('{10, ev(1'b0, 1'b0, 1'b0, 1'b1, 0), "idle_no_rearm"});

    // Power-up arm: one quarter-second timeout, full sequence, then stays idle.
    do_reset(1'b1, 1'b0, 3'd0);
    foreach (segs[s])
      for (int i = 0; i < segs[s].n; i++) cyc(1'b0, 1'b0, segs[s].want, segs[s].tag);

    // Load value per sanity code on RUN entry.
    for (int i = 0; i < 8; i++) begin
      do_reset(1'b0, 1'b1, ld_tab[i].code);
      cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, int'(ld_tab[i].rem)), "load_code");
    end

    // ena drop in RUN discards the counter; re-entry reloads.
    do_reset(1'b0, 1'b1, 3'd3);
    cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 64), "run_entry");
    cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 64), "run_hold");
    ena = 1'b0;
    cyc(1'b0, 1'b0, 18'h0, "ena_drop_idle");
    cyc(1'b0, 1'b0, 18'h0, "idle_stays");
    ena = 1'b1;
    sanity = 3'd0;
    cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 1), "reentry_reload");

    // Regular kicks every 12 cycles with a 1 s timeout: never below 2, never expires.
    do_reset(1'b0, 1'b1, 3'd1);
    for (int c = 1; c <= 200; c++) begin
      int j;
      j = (c - 1) % 12;
      cyc(c > 1 && j == 0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 4 - j / 4), "kick_every_12");
    end

    // Kick on the expiring tick wins; then expiry 64 cycles later.
    do_reset(1'b0, 1'b1, 3'd2);
    for (int c = 1; c <= 129; c++) begin
      int j;
      j = (c < 65) ? c - 1 : c - 65;
      w = (c == 129) ? seq_want(0) : ev(1'b0, 1'b0, 1'b0, 1'b0, 16 - j / 4);
      cyc(c == 65, 1'b0, w, "kick_on_expiry");
    end

    // Walk into DCKF, then assert rst mid-cycle: outputs clear before the next edge.
    for (int k = 1; k <= LO_START + 1; k++) cyc(1'b0, 1'b0, seq_want(k), "to_dckf");
    @(negedge clock);
    rst = 1'b1;
    #1;
    check("async_reset_dckf", outs, 18'h0);

    // clr_exp coincident with a new expiry keeps expired; clr_exp alone clears it.
    do_reset(1'b0, 1'b1, 3'd0);
    for (int c = 1; c <= 12 + SEQ_LEN; c++) begin
      logic clr;
      clr = 1'b0;
      if (c < 5) w = ev(1'b0, 1'b0, 1'b0, 1'b0, 1);
      else if (c <= 5 + SEQ_LEN) w = seq_want(c - 5);
      else if (c < 10 + SEQ_LEN) w = ev(1'b0, 1'b0, 1'b0, 1'b1, 1);
      else if (c == 10 + SEQ_LEN) begin w = seq_want(0); clr = 1'b1; end
      else if (c == 11 + SEQ_LEN) begin w = seq_want(1) & ~EXP_BIT; clr = 1'b1; end
      else w = seq_want(2) & ~EXP_BIT;
      cyc(1'b0, clr, w, "clr_exp_seq");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
